// File: rtl/coriolis_ker1_pkg.sv
// Shared definitions for the coriolis kernel-1 blocks: the offset-buffer
// controller state encoding and default buffer geometry.
package coriolis_ker1_pkg;

    localparam int KER1_SIZE_DEFAULT = 16;
    localparam int KER1_CNTW_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ker1_state_e;

    // A job is in flight (items may still be pushed or delivered).
    function automatic logic ker1_active(input ker1_state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/coriolis_ker1_offset_buf_ctrl.sv
// Job controller for the kernel-1 offset buffer (a SIZE-deep shift line owned
// by the parent). It gates the buffer's shift enable from the up/down
// handshakes, flushes the line with SIZE extra pushes at the end of each job,
// and masks tap valids until SIZE pushes of the current job have gone in, so
// valid bits left over from an earlier or abandoned job never reach the output.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting for start; counters hold the last job's values
//   ST_RUN   | accepting upstream items, one push per accepted item
//   ST_DRAIN | all items accepted; pushing filler to flush the last SIZE taps
//   ST_DONE  | one-cycle completion pulse, then back to ST_IDLE
module coriolis_ker1_offset_buf_ctrl
    import coriolis_ker1_pkg::*;
#(
    parameter int SIZE = KER1_SIZE_DEFAULT,
    parameter int CNTW = KER1_CNTW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [CNTW-1:0] nitems,
    input  logic            ivalid_up,
    output logic            iready_up,
    output logic            buf_ivalid,
    input  logic            buf_ovalid,
    output logic            ovalid_down,
    input  logic            oready_down,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] out_cnt
);

    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW:0]   PUSH_ONE = (CNTW + 1)'(1);
    localparam logic [CNTW:0]   SIZE_W   = (CNTW + 1)'(SIZE);

    ker1_state_e     state_q, state_d;
    logic [CNTW-1:0] nitems_q, nitems_d;
    logic [CNTW-1:0] in_cnt_q, in_cnt_d;
    logic [CNTW-1:0] out_cnt_q, out_cnt_d;
    logic [CNTW:0]   push_cnt_q, push_cnt_d;

    logic run_st;
    logic drain_st;
    logic push;
    logic accept;
    logic xfer;
    logic last_in;
    logic last_out;

    assign run_st   = (state_q == ST_RUN);
    assign drain_st = (state_q == ST_DRAIN);

    // Downstream backpressure freezes everything, including upstream intake,
    // so the shift line never moves while an output is being held.
    assign iready_up  = run_st & oready_down;
    assign accept     = ivalid_up & iready_up;
    assign push       = oready_down & ((run_st & ivalid_up) | drain_st);
    assign buf_ivalid = push;

    // Tap valids only belong to this job once SIZE of its own pushes are in.
    assign ovalid_down = buf_ovalid & (push_cnt_q >= SIZE_W) & ker1_active(state_q);
    assign xfer        = ovalid_down & oready_down;

    assign last_in  = (in_cnt_q == (nitems_q - CNT_ONE));
    assign last_out = (out_cnt_q == (nitems_q - CNT_ONE));

    assign busy    = ker1_active(state_q);
    assign done    = (state_q == ST_DONE);
    assign out_cnt = out_cnt_q;

    // Next-state and counter update; abort overrides every transition.
    always_comb begin
        state_d    = state_q;
        nitems_d   = nitems_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        push_cnt_d = push_cnt_q;

        if (accept) begin
            in_cnt_d = in_cnt_q + CNT_ONE;
        end
        if (xfer) begin
            out_cnt_d = out_cnt_q + CNT_ONE;
        end
        if (push) begin
            push_cnt_d = push_cnt_q + PUSH_ONE;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    nitems_d   = nitems;
                    in_cnt_d   = '0;
                    out_cnt_d  = '0;
                    push_cnt_d = '0;
                    state_d    = (nitems == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && last_in) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer && last_out) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // State and counter registers; reset discards any job in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            nitems_q   <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            push_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            nitems_q   <= nitems_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            push_cnt_q <= push_cnt_d;
        end
    end

endmodule

// File: tb/tb_coriolis_ker1_offset_buf_ctrl.sv
// Bench for coriolis_ker1_offset_buf_ctrl: a behavioural offset buffer
// (SIZE-deep shift line, tap valid qualified by the shift enable), a queue of
// accepted upstream items and a queue of delivered outputs, a table of jobs,
// and hand-written sequences for reset, empty jobs, abort and stalls.
module tb_coriolis_ker1_offset_buf_ctrl;

    localparam int SIZE = 16;
    localparam int CNTW = 32;
    localparam int MAXC = 600;
    localparam logic [31:0] FILL = 32'hF111_0000;

    typedef struct {
        int n;
        bit gaps;
        bit srun;
        bit sdrain;
        int exp_push;
        int exp_first;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [CNTW-1:0] nitems = '0;
    logic            ivalid_up = 1'b0;
    logic            oready_down = 1'b0;
    logic            iready_up;
    logic            buf_ivalid;
    logic            buf_ovalid;
    logic            ovalid_down;
    logic            busy;
    logic            done;
    logic [CNTW-1:0] out_cnt;

    always #5 clk = ~clk;

    coriolis_ker1_offset_buf_ctrl #(.SIZE(SIZE), .CNTW(CNTW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .nitems      (nitems),
        .ivalid_up   (ivalid_up),
        .iready_up   (iready_up),
        .buf_ivalid  (buf_ivalid),
        .buf_ovalid  (buf_ovalid),
        .ovalid_down (ovalid_down),
        .oready_down (oready_down),
        .busy        (busy),
        .done        (done),
        .out_cnt     (out_cnt)
    );

    // Offset buffer model: never reset, so stale valids survive between jobs.
    logic [31:0] bdat [SIZE] = '{default: 32'h0};
    logic        bvld [SIZE] = '{default: 1'b0};
    logic [31:0] buf_data;
    logic [31:0] up_data = 32'h0;
    logic        tb_clr = 1'b0;
    logic        clr_mon = 1'b0;
    logic        m_push = 1'b0;
    logic        m_acc = 1'b0;

    assign buf_ovalid = buf_ivalid & bvld[SIZE-1];
    assign buf_data   = bdat[SIZE-1];

    always @(posedge clk) begin
        if (m_push) begin
            for (int i = SIZE - 1; i > 0; i--) begin
                bdat[i] <= bdat[i-1];
                bvld[i] <= bvld[i-1];
            end
            bdat[0] <= m_acc ? up_data : FILL;
            bvld[0] <= 1'b1;
        end
        if (tb_clr) up_data <= 32'h0;
        else if (m_acc) up_data <= up_data + 32'h1;
    end

    // Monitor: records pushes, accepted items (expected) and delivered items.
    int          cyc = 0;
    int          push_n = 0;
    int          acc_n = 0;
    int          out_n = 0;
    int          first_ov = 0;
    int          last_xfer = 0;
    int          done_cyc = 0;
    bit          busy_seen = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] act_q[$];

    always @(negedge clk) begin
        m_push = buf_ivalid;
        m_acc  = ivalid_up & iready_up;
        if (clr_mon) begin
            push_n = 0; acc_n = 0; out_n = 0; first_ov = 0;
            last_xfer = 0; done_cyc = 0; busy_seen = 1'b0;
            exp_q.delete();
            act_q.delete();
        end else begin
            if (buf_ivalid) push_n++;
            if (ivalid_up && iready_up) begin
                exp_q.push_back(up_data);
                acc_n++;
            end
            if (ovalid_down && oready_down) begin
                if (first_ov == 0) first_ov = push_n;
                act_q.push_back(buf_data);
                out_n++;
                last_xfer = cyc;
            end
            if (done) done_cyc = cyc;
            if (busy) busy_seen = 1'b1;
        end
        cyc++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_job(input int n);
        @(posedge clk); #1;
        clr_mon = 1'b1; tb_clr = 1'b1; start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        clr_mon = 1'b0; tb_clr = 1'b0; start = 1'b1; nitems = CNTW'(n);
    endtask

    task automatic stall3(input string tag);
        logic [CNTW-1:0] fr;
        oready_down = 1'b0;
        fr = out_cnt;
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_stall_push"}, buf_ivalid, 0);
            chk({tag, "_stall_iready"}, iready_up, 0);
            chk({tag, "_stall_outcnt"}, out_cnt, fr);
            @(posedge clk); #1;
        end
        chk({tag, "_stall_hold"}, out_cnt, fr);
        oready_down = 1'b1;
    endtask

    task automatic run_job(input vec_t v, input string tag);
        bit seen, sr, sd;
        seen = 1'b0; sr = 1'b0; sd = 1'b0;
        start_job(v.n);
        for (int c = 0; c < MAXC && !seen; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            ivalid_up = v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            oready_down = 1'b1;
            if (v.srun && !sr && busy && acc_n >= v.n / 2 && acc_n < v.n) begin
                stall3({tag, "_run"});
                sr = 1'b1;
            end else if (v.sdrain && !sd && busy && acc_n == v.n) begin
                stall3({tag, "_drain"});
                sd = 1'b1;
            end
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_done_seen"}, seen, 1);
        if (v.srun) chk({tag, "_run_stall_hit"}, sr, 1);
        if (v.sdrain) chk({tag, "_drain_stall_hit"}, sd, 1);
        chk({tag, "_pushes"}, push_n, v.exp_push);
        chk({tag, "_outputs"}, out_n, v.n);
        chk({tag, "_accepted"}, exp_q.size(), v.n);
        chk({tag, "_first_ovalid_push"}, first_ov, v.exp_first);
        chk({tag, "_done_latency"}, done_cyc, last_xfer + 1);
        chk({tag, "_out_cnt"}, out_cnt, v.n);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_after"}, busy, 0);
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_data[%0d]", tag, i), act_q[i], exp_q[i]);
        end
    endtask

    vec_t vecs [6];
    vec_t v;

    initial begin
        vecs[0] = '{n: 40, gaps: 0, srun: 0, sdrain: 0, exp_push: 56, exp_first: 17};
        vecs[1] = '{n: 5,  gaps: 0, srun: 0, sdrain: 0, exp_push: 21, exp_first: 17};
        vecs[2] = '{n: 20, gaps: 1, srun: 1, sdrain: 1, exp_push: 36, exp_first: 17};
        vecs[3] = '{n: 1,  gaps: 0, srun: 0, sdrain: 1, exp_push: 17, exp_first: 17};
        vecs[4] = '{n: 16, gaps: 1, srun: 0, sdrain: 0, exp_push: 32, exp_first: 17};
        vecs[5] = '{n: 33, gaps: 1, srun: 1, sdrain: 1, exp_push: 49, exp_first: 17};

        // Reset holds every output low even with inputs active.
        rst = 1'b0; ivalid_up = 1'b1; oready_down = 1'b1; start = 1'b1; nitems = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_buf_ivalid", buf_ivalid, 0);
        chk("rst_iready", iready_up, 0);
        chk("rst_ovalid", ovalid_down, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_cnt", out_cnt, 0);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Abort wins over a simultaneous start.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; nitems = '0;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort_prio_done", done, 0);
        chk("abort_prio_busy", busy, 0);

        // Empty job: done on the next cycle, no push, never busy.
        start_job(0);
        @(negedge clk);
        chk("empty_no_push", buf_ivalid, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("empty_done", done, 1);
        chk("empty_busy", busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("empty_done_pulse", done, 0);
        @(posedge clk); #1;
        chk("empty_pushes", push_n, 0);
        chk("empty_busy_seen", busy_seen, 0);

        for (int k = 0; k < 6; k++) begin
            run_job(vecs[k], $sformatf("vec%0d", k));
        end

        // Abort in the middle of DRAIN, then a clean job over stale valids.
        start_job(10);
        for (int c = 0; c < 100 && acc_n < 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0; ivalid_up = 1'b1; oready_down = 1'b1;
            @(negedge clk);
        end
        chk("abort_job_accepted", acc_n, 10);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("abort_drain_busy", busy, 1);
        chk("abort_drain_iready", iready_up, 0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        v = '{n: 20, gaps: 0, srun: 0, sdrain: 0, exp_push: 36, exp_first: 17};
        run_job(v, "post_abort");

        // Reset pulsed in the middle of RUN, then a clean job.
        start_job(30);
        repeat (22) begin
            @(posedge clk); #1;
            start = 1'b0; ivalid_up = 1'b1; oready_down = 1'b1;
        end
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_buf_ivalid", buf_ivalid, 0);
        chk("mid_rst_iready", iready_up, 0);
        chk("mid_rst_ovalid", ovalid_down, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_out_cnt", out_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        v = '{n: 12, gaps: 1, srun: 0, sdrain: 0, exp_push: 28, exp_first: 17};
        run_job(v, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
